// File: rtl/boruss_prog_loader.sv
// Program loader and 256x8 instruction store for BorussCPU: receives a framed, XOR-checked
// byte stream and serves combinational instruction fetches; holds the CPU in reset until a load verifies.
module boruss_prog_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0]  FILL_BYTE      = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] instruction_addr,
  output logic [7:0] instruction_data,
  output logic       cpu_reset_n,
  output logic       load_busy,
  output logic       load_done,
  output logic       load_error,
  output logic [8:0] prog_len
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_VERIFY, ST_DONE, ST_ERROR
  } state_t;

  state_t      state;
  logic [7:0]  mem [256];
  logic [8:0]  len;
  logic [7:0]  acc;
  logic [7:0]  wr_ptr;
  logic [15:0] tcnt;
  logic        match;
  logic        accept;
  logic        wr_en;
  logic        in_frame;

  assign accept   = s_valid & s_ready;
  assign wr_en    = accept && (state == ST_DATA);
  assign in_frame = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);

  // Status outputs are pure decodes of the state register, so they change only on clock edges.
  assign s_ready     = (state != ST_VERIFY);
  assign cpu_reset_n = (state == ST_DONE);
  assign load_busy   = in_frame || (state == ST_VERIFY);

  // prog_len is forced to 0 for the whole frame, so partially written RAM is never visible.
  assign instruction_data = ({1'b0, instruction_addr} < prog_len) ? mem[instruction_addr] : FILL_BYTE;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      len        <= 9'd0;
      acc        <= 8'd0;
      wr_ptr     <= 8'd0;
      tcnt       <= 16'd0;
      match      <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      prog_len   <= 9'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (accept && (s_data == SYNC_BYTE)) begin
            state      <= ST_LEN;
            prog_len   <= 9'd0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            tcnt       <= 16'd0;
          end
        end
        ST_LEN: begin
          if (accept) begin
            len    <= (s_data == 8'd0) ? 9'd256 : {1'b0, s_data};
            acc    <= s_data;
            wr_ptr <= 8'd0;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            acc    <= acc ^ s_data;
            wr_ptr <= wr_ptr + 8'd1;
            if ({1'b0, wr_ptr} == (len - 9'd1)) state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (accept) begin
            match <= (s_data == acc);
            state <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (match) begin
            state     <= ST_DONE;
            prog_len  <= len;
            load_done <= 1'b1;
          end else begin
            state      <= ST_ERROR;
            load_error <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Inter-byte watchdog; overrides any frame-state decision above on expiry.
      if (in_frame) begin
        if (accept) begin
          tcnt <= 16'd0;
        end else if (tcnt == (TIMEOUT_CYCLES - 16'd1)) begin
          tcnt       <= 16'd0;
          state      <= ST_ERROR;
          load_error <= 1'b1;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_boruss_prog_loader.sv
// Directed bench for boruss_prog_loader: framing, checksum, timeout, 256-byte load, reload, reset.
module tb_boruss_prog_loader;

  localparam logic [15:0] TMO = 16'd64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] instruction_addr;
  logic [7:0] instruction_data;
  logic       cpu_reset_n;
  logic       load_busy;
  logic       load_done;
  logic       load_error;
  logic [8:0] prog_len;

  int errors = 0;
  int checks = 0;

  boruss_prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .instruction_addr(instruction_addr), .instruction_data(instruction_data),
    .cpu_reset_n(cpu_reset_n), .load_busy(load_busy), .load_done(load_done),
    .load_error(load_error), .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  // Sends one byte after `gap` idle cycles; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_data = b; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 10) begin @(negedge clk); n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_ready_timeout byte=%h s_ready=%b required 1", b, s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    instruction_addr = a; #1;
    checks++;
    if (instruction_data !== exp) begin
      errors++; $display("FAIL %s addr=%h got=%h required=%h", name, a, instruction_data, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b0; s_data = 8'h00; instruction_addr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%b required=1", s_ready); end
    checks++; if (cpu_reset_n !== 1'b0) begin errors++; $display("FAIL rst_cpu_reset_n got=%b required=0", cpu_reset_n); end
    checks++; if ({load_busy, load_done, load_error} !== 3'b000) begin errors++; $display("FAIL rst_status got=%b required=000", {load_busy, load_done, load_error}); end
    checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL rst_prog_len got=%0d required=0", prog_len); end
    rd(8'h00, 8'hFF, "rst_read");
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_good_load();
    send(8'h11, 0);
    checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL noise_ignored busy got=%b required=0", load_busy); end
    send(8'hA5, 0);
    checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL sof_busy got=%b required=1", load_busy); end
    send(8'h03, 0); send(8'h10, 0); send(8'h2C, 0); send(8'h05, 0);
    send(8'h3A, 0);
    checks++; if ({s_ready, load_busy, cpu_reset_n} !== 3'b010) begin errors++; $display("FAIL verify_cycle rdy_busy_rstn got=%b required=010", {s_ready, load_busy, cpu_reset_n}); end
    @(posedge clk); #1;
    checks++; if ({cpu_reset_n, load_done, load_error, s_ready} !== 4'b1101) begin errors++; $display("FAIL good_done rstn_done_err_rdy got=%b required=1101", {cpu_reset_n, load_done, load_error, s_ready}); end
    checks++; if (prog_len !== 9'd3) begin errors++; $display("FAIL good_prog_len got=%0d required=3", prog_len); end
    rd(8'h00, 8'h10, "good_a0"); rd(8'h01, 8'h2C, "good_a1"); rd(8'h02, 8'h05, "good_a2"); rd(8'h03, 8'hFF, "good_a3");
  endtask

  task automatic test_reload_bad_csum();
    send(8'h42, 0);
    checks++; if (cpu_reset_n !== 1'b1) begin errors++; $display("FAIL done_noise rstn got=%b required=1", cpu_reset_n); end
    send(8'hA5, 0);
    checks++; if ({cpu_reset_n, load_done, load_busy} !== 3'b001) begin errors++; $display("FAIL reload_start rstn_done_busy got=%b required=001", {cpu_reset_n, load_done, load_busy}); end
    checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL reload_prog_len got=%0d required=0", prog_len); end
    rd(8'h00, 8'hFF, "reload_a0");
    send(8'h03, 0); send(8'h10, 0); send(8'h2C, 0); send(8'h05, 0); send(8'h3B, 0);
    @(posedge clk); #1;
    checks++; if ({load_error, load_done, cpu_reset_n, load_busy} !== 4'b1000) begin errors++; $display("FAIL bad_csum err_done_rstn_busy got=%b required=1000", {load_error, load_done, cpu_reset_n, load_busy}); end
    checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL bad_prog_len got=%0d required=0", prog_len); end
    rd(8'h00, 8'hFF, "bad_a0");
  endtask

  task automatic test_timeout();
    send(8'hA5, 0); send(8'h02, 0); send(8'h10, 0);
    repeat (TMO - 2) @(posedge clk);
    #1;
    checks++; if ({load_busy, load_error} !== 2'b10) begin errors++; $display("FAIL tmo_early busy_err got=%b required=10", {load_busy, load_error}); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if ({load_busy, load_error, cpu_reset_n} !== 3'b010) begin errors++; $display("FAIL tmo_expired busy_err_rstn got=%b required=010", {load_busy, load_error, cpu_reset_n}); end
    send(8'hA5, 0); send(8'h01, 0); send(8'h77, 0); send(8'h76, 0);
    @(posedge clk); #1;
    checks++; if ({load_done, load_error, prog_len} !== {2'b10, 9'd1}) begin errors++; $display("FAIL tmo_recover done_err_len got=%b required=%b", {load_done, load_error, prog_len}, {2'b10, 9'd1}); end
    rd(8'h00, 8'h77, "tmo_a0"); rd(8'h01, 8'hFF, "tmo_a1");
  endtask

  task automatic test_full_256();
    send(8'hA5, 0); send(8'h00, 0);
    for (int i = 0; i < 256; i++) send(i[7:0], 0);
    checks++; if ({load_busy, s_ready} !== 2'b11) begin errors++; $display("FAIL f256_csum_wait busy_rdy got=%b required=11", {load_busy, s_ready}); end
    send(8'h00, 0);
    @(posedge clk); #1;
    checks++; if ({load_done, prog_len} !== {1'b1, 9'd256}) begin errors++; $display("FAIL f256_done done_len got=%b required=%b", {load_done, prog_len}, {1'b1, 9'd256}); end
    rd(8'h00, 8'h00, "f256_a0"); rd(8'h80, 8'h80, "f256_a128"); rd(8'hFE, 8'hFE, "f256_a254"); rd(8'hFF, 8'hFF, "f256_a255");
  endtask

  task automatic test_backpressure_sync_as_data();
    // A5 inside the payload is data; random gaps stay well under the timeout.
    send(8'hA5, $urandom_range(0, 5)); send(8'h02, $urandom_range(0, 5));
    send(8'hA5, $urandom_range(0, 5)); send(8'h01, $urandom_range(0, 5));
    send(8'hA6, $urandom_range(0, 5));
    @(posedge clk); #1;
    checks++; if ({load_done, load_error, cpu_reset_n, prog_len} !== {3'b101, 9'd2}) begin errors++; $display("FAIL bp_done done_err_rstn_len got=%b required=%b", {load_done, load_error, cpu_reset_n, prog_len}, {3'b101, 9'd2}); end
    rd(8'h00, 8'hA5, "bp_a0"); rd(8'h01, 8'h01, "bp_a1"); rd(8'h02, 8'hFF, "bp_a2");
  endtask

  task automatic test_async_reset();
    send(8'hA5, 0); send(8'h03, 0); send(8'h10, 0);
    @(negedge clk); #2;
    reset = 1'b0; #1;
    checks++; if ({load_busy, s_ready, cpu_reset_n, load_done, prog_len} !== {4'b0100, 9'd0}) begin errors++; $display("FAIL async_rst busy_rdy_rstn_done_len got=%b required=%b", {load_busy, s_ready, cpu_reset_n, load_done, prog_len}, {4'b0100, 9'd0}); end
    rd(8'h00, 8'hFF, "async_a0");
    @(negedge clk); reset = 1'b1;
    send(8'h03, 0);
    checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL async_idle busy got=%b required=0", load_busy); end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_reload_bad_csum();
    test_timeout();
    test_full_256();
    test_backpressure_sync_as_data();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
